// File: rtl/shiftreg_seq_ctrl.sv
// Word-to-bit-stream serialiser with valid/ready word intake and a downstream shift-enable stall.
// Optional even-parity trailer bit when SHIFTREG_SEQ_CTRL_PARITY_EN is defined.
module shiftreg_seq_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CW = $clog2(NBITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             accept;
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
  logic             par_q, par_d;
`endif

  // cnt_q counts bits still to come after the one currently on sout;
  // the first bit is placed on sout at accept, so sreg holds only the remainder.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    sout_d    = sout_q;
    valid_d   = valid_q;
    last_d    = last_q;
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
    par_d     = par_q;
`endif
    din_ready = clear & ((state_q == IDLE) |
                         ((state_q == SHIFT) & (cnt_q == '0) & shift_en));
    accept    = din_valid & din_ready;

    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CW'(NBITS - 1);
      valid_d = 1'b1;
      last_d  = 1'b0;
      if (MSB_FIRST) begin
        sout_d = din[WIDTH-1];
        sreg_d = {din[WIDTH-2:0], 1'b0};
      end else begin
        sout_d = din[0];
        sreg_d = {1'b0, din[WIDTH-1:1]};
      end
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
      par_d = ^din;
`endif
    end else if ((state_q == SHIFT) && shift_en) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q - CW'(1);
        last_d = (cnt_q == CW'(1));
        if (MSB_FIRST) begin
          sout_d = sreg_q[WIDTH-1];
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
          sout_d = sreg_q[0];
          sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
        end
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
        if (cnt_q == CW'(1)) sout_d = par_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_last  = last_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Bench for shiftreg_seq_ctrl: MSB-first and LSB-first instances on shared inputs,
// checked every cycle against a bit-queue model of the word stream.
module tb_shiftreg_seq_ctrl;
  localparam int unsigned WIDTH = 4;
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
  localparam int unsigned NB = WIDTH + 1;
  localparam logic [15:0] BASIC_M = 16'b10111;
  localparam logic [15:0] BASIC_L = 16'b11011;
  localparam logic [15:0] B2B_M   = 16'b1100000110;
`else
  localparam int unsigned NB = WIDTH;
  localparam logic [15:0] BASIC_M = 16'b1011;
  localparam logic [15:0] BASIC_L = 16'b1101;
  localparam logic [15:0] B2B_M   = 16'b11000011;
`endif

  logic             clk = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             shift_en = 1'b0;
  logic             rdy_m, sout_m, val_m, last_m, busy_m;
  logic             rdy_l, sout_l, val_l, last_l, busy_l;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit qm[$];
  bit ql[$];
  bit last_acc;

  shiftreg_seq_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .shift_en(shift_en), .sout(sout_m), .sout_valid(val_m), .sout_last(last_m), .busy(busy_m));

  shiftreg_seq_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .shift_en(shift_en), .sout(sout_l), .sout_valid(val_l), .sout_last(last_l), .busy(busy_l));

  always #5 clk = ~clk;

  // Model: queue holds the bits of the word in flight; head is the bit on sout.
  function automatic logic mdl_ready();
    return clear && ((qm.size() == 0) || ((qm.size() == 1) && shift_en));
  endfunction

  function automatic logic [9:0] exp_vec();
    logic r;
    r = mdl_ready();
    return {r, r,
            qm.size() != 0, qm.size() == 1, (qm.size() != 0) ? qm[0] : 1'b0, qm.size() != 0,
            ql.size() != 0, ql.size() == 1, (ql.size() != 0) ? ql[0] : 1'b0, ql.size() != 0};
  endfunction

  function automatic logic [9:0] act_vec();
    return {rdy_m, rdy_l, val_m, last_m, sout_m, busy_m, val_l, last_l, sout_l, busy_l};
  endfunction

  task automatic cyc();
    bit rdy;
    bit par;
    @(posedge clk);
    rdy = mdl_ready();
    last_acc = 1'b0;
    if (!clear) begin
      qm.delete();
      ql.delete();
    end else begin
      if ((qm.size() != 0) && shift_en) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (din_valid && rdy) begin
        last_acc = 1'b1;
        par = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          qm.push_back(din[WIDTH-1-i]);
          ql.push_back(din[i]);
          par = par ^ din[i];
        end
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
        qm.push_back(par);
        ql.push_back(par);
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; din_valid = 1'b1; din = WIDTH'($urandom); shift_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      tot_cnt++;
      if (act_vec() !== exp_vec())
        $display("FAIL reset c%0d act=%b exp=%b", c, act_vec(), exp_vec());
      else pass_cnt++;
    end
    tot_cnt++;
    if ({rdy_m, val_m, busy_m, busy_l} !== 4'b0000)
      $display("FAIL reset_idle act=%b exp=0000", {rdy_m, val_m, busy_m, busy_l});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [15:0] sm, sl;
    sm = '0; sl = '0;
    clear = 1'b1; shift_en = 1'b1;
    for (int c = 0; c < NB + 4; c++) begin
      din_valid = (c == 0); din = 4'b1011;
      #1;
      tot_cnt++;
      if (act_vec() !== exp_vec())
        $display("FAIL basic c%0d act=%b exp=%b", c, act_vec(), exp_vec());
      else pass_cnt++;
      if (val_m && shift_en) sm = {sm[14:0], sout_m};
      if (val_l && shift_en) sl = {sl[14:0], sout_l};
      cyc();
    end
    tot_cnt++;
    if (sm !== BASIC_M) $display("FAIL basic_msb_seq act=%b exp=%b", sm, BASIC_M);
    else pass_cnt++;
    tot_cnt++;
    if (sl !== BASIC_L) $display("FAIL basic_lsb_seq act=%b exp=%b", sl, BASIC_L);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int nvalid;
    logic [15:0] sm;
    nvalid = 0; sm = '0;
    for (int c = 0; c < NB + 6; c++) begin
      din_valid = (c == 0); din = 4'b1011;
      shift_en = !(c == 2 || c == 3);
      #1;
      tot_cnt++;
      if (act_vec() !== exp_vec())
        $display("FAIL stall c%0d act=%b exp=%b", c, act_vec(), exp_vec());
      else pass_cnt++;
      if (val_m) nvalid++;
      if (val_m && shift_en) sm = {sm[14:0], sout_m};
      cyc();
    end
    tot_cnt++;
    if (nvalid != NB + 2) $display("FAIL stall_len act=%0d exp=%0d", nvalid, NB + 2);
    else pass_cnt++;
    tot_cnt++;
    if (sm !== BASIC_M) $display("FAIL stall_seq act=%b exp=%b", sm, BASIC_M);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int nacc, nvalid, nlast;
    logic [15:0] sm;
    nacc = 0; nvalid = 0; nlast = 0; sm = '0;
    shift_en = 1'b1;
    for (int c = 0; c < 2 * NB + 4; c++) begin
      din_valid = (nacc < 2);
      din = (nacc == 0) ? 4'b1100 : 4'b0011;
      #1;
      tot_cnt++;
      if (act_vec() !== exp_vec())
        $display("FAIL b2b c%0d act=%b exp=%b", c, act_vec(), exp_vec());
      else pass_cnt++;
      if (val_m) nvalid++;
      if (last_m) nlast++;
      if (val_m && shift_en) sm = {sm[14:0], sout_m};
      cyc();
      if (last_acc) nacc++;
    end
    tot_cnt++;
    if (sm !== B2B_M) $display("FAIL b2b_seq act=%b exp=%b", sm, B2B_M);
    else pass_cnt++;
    tot_cnt++;
    if (nvalid != 2 * NB || nlast != 2)
      $display("FAIL b2b_count act=%0d/%0d exp=%0d/2", nvalid, nlast, 2 * NB);
    else pass_cnt++;
  endtask

  task automatic test_midclear();
    shift_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      din_valid = (c == 0); din = WIDTH'($urandom);
      clear = (c != 3);
      #1;
      tot_cnt++;
      if (act_vec() !== exp_vec())
        $display("FAIL midclear c%0d act=%b exp=%b", c, act_vec(), exp_vec());
      else pass_cnt++;
      cyc();
      if (c == 3) begin
        tot_cnt++;
        if ({val_m, busy_m, val_l, busy_l} !== 4'b0000)
          $display("FAIL midclear_abandon act=%b exp=0000", {val_m, busy_m, val_l, busy_l});
        else pass_cnt++;
      end
    end
    clear = 1'b1;
  endtask

`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
  task automatic test_parity();
    logic [15:0] sm;
    logic lastbit;
    sm = '0; lastbit = 1'b0;
    shift_en = 1'b1;
    for (int c = 0; c < NB + 3; c++) begin
      din_valid = (c == 0); din = 4'b0111;
      #1;
      tot_cnt++;
      if (act_vec() !== exp_vec())
        $display("FAIL parity c%0d act=%b exp=%b", c, act_vec(), exp_vec());
      else pass_cnt++;
      if (val_m && shift_en) sm = {sm[14:0], sout_m};
      if (last_m) lastbit = sout_m;
      cyc();
    end
    tot_cnt++;
    if (sm !== 16'b01111 || lastbit !== 1'b1)
      $display("FAIL parity_seq act=%b/%b exp=0000000000001111/1", sm, lastbit);
    else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    logic [WIDTH-1:0] word;
    word = WIDTH'($urandom);
    for (int c = 0; c < 400; c++) begin
      clear     = ($urandom_range(0, 99) >= 3);
      din_valid = ($urandom_range(0, 99) < 60);
      shift_en  = ($urandom_range(0, 99) < 75);
      din       = word;
      #1;
      tot_cnt++;
      if (act_vec() !== exp_vec())
        $display("FAIL random c%0d act=%b exp=%b", c, act_vec(), exp_vec());
      else pass_cnt++;
      cyc();
      if (last_acc || !din_valid) word = WIDTH'($urandom);
    end
    clear = 1'b1; din_valid = 1'b0; shift_en = 1'b1;
    for (int c = 0; c < NB + 2; c++) cyc();
    tot_cnt++;
    if ({val_m, busy_m, val_l, busy_l} !== 4'b0000 || qm.size() != 0)
      $display("FAIL random_drain act=%b exp=0000", {val_m, busy_m, val_l, busy_l});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_midclear();
`ifdef SHIFTREG_SEQ_CTRL_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/shiftreg_seq_ctrl.md
Name: shiftreg_seq_ctrl

Overview:
Sequencer that serialises parallel words through an internal WIDTH-bit shift register, one bit per enabled clock. Accepts words on a valid/ready handshake and emits a bit stream with per-bit valid and end-of-word markers. A shift-enable input lets the downstream stall the stream. Sits between a parallel word source and any serial sink, such as a chained shift-register stage or a serial link.

Parameters:
WIDTH, 4, data word width in bits (>= 2).
MSB_FIRST, 1, 1 = emit data[WIDTH-1] first; 0 = emit data[0] first.

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous active-low reset
din  input  WIDTH  parallel word to serialise
din_valid  input  1  din is valid
din_ready  output  1  block can accept din this cycle
shift_en  input  1  advance the stream this cycle; 0 = stall
sout  output  1  serial data bit (registered)
sout_valid  output  1  sout holds a valid bit (registered)
sout_last  output  1  sout is the final bit of the word (registered)
busy  output  1  word in flight (state != IDLE)

Behaviour:
- Reset: clk is the only clock; clear is sampled on the rising edge of clk (synchronous, active-low). While clear = 0:
  - state <= IDLE; shift register, bit counter, sout, sout_valid and sout_last <= 0.
  - din_ready = 0; all inputs are ignored.
  - Asserting clear mid-word abandons the word. No further bits are emitted.
- States: IDLE and SHIFT.
- din_ready (combinational) = clear & ((state == IDLE) | (state == SHIFT & cnt == 0 & shift_en)).
- Accept occurs at an edge where din_valid & din_ready. On accept:
  - load din into the shift register;
  - cnt <= NBITS-1, where NBITS = WIDTH, or WIDTH+1 with parity;
  - state <= SHIFT;
  - first bit is presented on sout with sout_valid = 1 in the cycle after the accept edge.
- IDLE: sout_valid = 0, sout_last = 0; sout holds 0.
- SHIFT, when shift_en = 1 at an edge:
  - next bit is presented; shift register shifts toward the emit end; cnt decrements;
  - sout_last = 1 exactly while the final bit is presented;
  - when cnt == 0, the current bit is the last one: go to IDLE, or stay in SHIFT if a new word is accepted at that same edge.
- SHIFT, when shift_en = 0: sout, sout_valid, sout_last, cnt and shift register all hold. No bit is consumed.
- The sink consumes a bit at each edge where sout_valid & shift_en.
- Back-to-back words: a new word accepted on the edge that consumes the last bit puts its first bit on sout the next cycle. sout_valid does not drop between words.
- Latency: accept edge to first bit = 1 cycle. Word occupies NBITS enabled cycles.
- Throughput: one bit per cycle with shift_en held at 1.
- Bit order: MSB_FIRST = 1 gives din[WIDTH-1] … din[0]; MSB_FIRST = 0 gives din[0] … din[WIDTH-1].
- busy = 1 from the cycle after accept until the cycle after the last bit is consumed, unless a back-to-back word follows.
- din_valid while din_ready = 0: no accept; the source must hold din.

Optional Feature:
SHIFTREG_SEQ_CTRL_PARITY_EN
- Defined: NBITS = WIDTH+1. After the data bits, one even-parity bit (XOR of all din bits) is emitted. sout_last marks the parity bit, not the final data bit.
- Undefined: NBITS = WIDTH; no parity bit; sout_last marks the final data bit.
- Ports are identical in both builds.

Test Plan:
- Reset check: hold clear = 0 for 3 cycles with din_valid = 1 -> din_ready = 0, sout_valid = 0, busy = 0 throughout; no word accepted.
- Basic serialise (WIDTH = 4, MSB_FIRST = 1): send din = 4'b1011, shift_en = 1 -> sout = 1, 0, 1, 1 on cycles T+1..T+4; sout_last = 1 only at T+4; IDLE at T+5.
- LSB-first order (MSB_FIRST = 0): send din = 4'b1011 -> sout = 1, 1, 0, 1.
- Stall: drop shift_en for 2 cycles after the second bit -> second bit held 2 extra cycles with sout_valid = 1; sequence completes in 6 cycles and is otherwise unchanged.
- Back-to-back: din_valid held with 4'b1100 then 4'b0011 -> 8 contiguous valid bits 1, 1, 0, 0, 0, 0, 1, 1; sout_last at bits 4 and 8; din_ready = 1 only on those edges.
- Mid-word clear after 2 bits -> next cycle sout_valid = 0; state IDLE. Parity build: din = 4'b0111 gives a fifth bit = 1 with sout_last on it.
